adc_fifo_reader: RTL

ADC_FIFO_READER -- requirements
Module: adc_fifo_reader

---
 rtl/scope_pkg.sv | 37 +++
 rtl/timeout_counter.sv | 29 ++
 rtl/adc_fifo_reader.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/scope_pkg.sv
// Shared types and defaults for the ADC capture/drain path.
// FSM encoding, output bundle and counter sizing live here.
package scope_pkg;

  typedef enum logic [3:0] {
    IDLE,
    CLEAR,
    ARM,
    WAIT_FULL,
    HEADER,
    RD_REQ,
    RD_LAT,
    SEND,
    DONE
  } state_t;

  typedef struct packed {
    logic bg;
    logic sclr;
    logic rd;
    logic hdr;
    logic snd;
    logic busy;
    logic done;
  } fsm_out_t;

  localparam int         CNT_W           = 11;
  localparam logic [7:0] HDR_BYTE_DEF    = 8'hA5;
  localparam int         FRAME_LEN_DEF   = 1024;
  localparam int         TIMEOUT_CYC_DEF = 2**20;

  // Bits needed to count 0 .. cyc-1.
  function automatic int to_width(input int cyc);
    return (cyc < 2) ? 1 : $clog2(cyc);
  endfunction

endpackage

// File: rtl/timeout_counter.sv
// Loadable up-counter that parks on its terminal count.
// Used to bound how long the capture may take to fill.
module timeout_counter #(
  parameter int           W    = 20,
  parameter logic [W-1:0] TERM = '1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         tc
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && !tc) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tc = (cnt == TERM);

endmodule

// File: rtl/adc_fifo_reader.sv
// Arms an ADC capture into a FIFO, then drains it to a byte link
// as a header byte followed by the captured samples.
module adc_fifo_reader
  import scope_pkg::*;
#(
  parameter int                DATA_W      = 8,
  parameter int                FRAME_LEN   = FRAME_LEN_DEF,
  parameter logic [DATA_W-1:0] HDR_BYTE    = DATA_W'(HDR_BYTE_DEF),
  parameter int                TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Start,
  output logic              ADC_bg,
  output logic              FIFO_sclr,
  input  logic              FIFO_full,
  input  logic              FIFO_almost_full,
  input  logic              FIFO_empty,
  output logic              FIFO_rdreq,
  input  logic [DATA_W-1:0] FIFO_q,
  output logic [DATA_W-1:0] Tx_data,
  output logic              Tx_valid,
  input  logic              Tx_ready,
  output logic              Busy,
  output logic              Frame_done,
  output logic              Timeout,
  output logic [CNT_W-1:0]  Frame_cnt
);

  localparam int TO_W = to_width(TIMEOUT_CYC);
  localparam logic [TO_W-1:0] TO_TERM =
    TO_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] FLEN =
    CNT_W'(FRAME_LEN);
  localparam logic [CNT_W-1:0] FLEN_M1 =
    CNT_W'(FRAME_LEN - 1);

  state_t            state;
  state_t            state_nxt;
  fsm_out_t          fo;
  logic [CNT_W-1:0]  smp_cnt;
  logic [DATA_W-1:0] tx_hold;
  logic              to_tc;
  logic              flag_hit;
  logic              to_hit;
  logic              start_ok;
  logic              tx_xfer;

  assign flag_hit = FIFO_full || FIFO_almost_full;
  assign to_hit   = (state == WAIT_FULL) &&
                    !flag_hit && to_tc;
  assign start_ok = (state == IDLE) && Start;
  assign tx_xfer  = (state == SEND) && Tx_ready;

  timeout_counter #(
    .W    (TO_W),
    .TERM (TO_TERM)
  ) u_timeout (
    .clk      (Clk),
    .rst_n    (Reset_n),
    .load     (state == ARM),
    .load_val ('0),
    .en       (state == WAIT_FULL),
    .tc       (to_tc)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (Start) state_nxt = CLEAR;
      end
      CLEAR: state_nxt = ARM;
      ARM:   state_nxt = WAIT_FULL;
      // A full flag outranks a coincident timeout.
      WAIT_FULL: begin
        if (flag_hit)   state_nxt = HEADER;
        else if (to_tc) state_nxt = DONE;
      end
      HEADER: begin
        if (Tx_ready) state_nxt = RD_REQ;
      end
      RD_REQ: begin
        if (FIFO_empty) state_nxt = DONE;
        else            state_nxt = RD_LAT;
      end
      RD_LAT: state_nxt = SEND;
      SEND: begin
        if (Tx_ready) begin
          if (smp_cnt >= FLEN_M1) state_nxt = DONE;
          else                    state_nxt = RD_REQ;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    fo      = '0;
    fo.busy = (state != IDLE);
    unique case (state)
      CLEAR:     fo.sclr = 1'b1;
      ARM:       fo.bg   = 1'b1;
      WAIT_FULL: fo.bg   = 1'b1;
      HEADER:    fo.hdr  = 1'b1;
      RD_REQ:    fo.rd   = 1'b1;
      SEND:      fo.snd  = 1'b1;
      DONE:      fo.done = 1'b1;
      default:   fo.busy = (state != IDLE);
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      smp_cnt <= '0;
    end else if (state == CLEAR) begin
      smp_cnt <= '0;
    end else if (tx_xfer && (smp_cnt < FLEN)) begin
      smp_cnt <= smp_cnt + 1'b1;
    end
  end

  // FIFO_q is valid the cycle after rdreq, i.e. in RD_LAT.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      tx_hold <= '0;
    end else if (state == RD_LAT) begin
      tx_hold <= FIFO_q;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      Timeout <= 1'b0;
    end else if (start_ok) begin
      Timeout <= 1'b0;
    end else if (to_hit) begin
      Timeout <= 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      Frame_cnt <= '0;
    end else if (state == DONE) begin
      Frame_cnt <= smp_cnt;
    end
  end

  assign ADC_bg     = fo.bg;
  assign FIFO_sclr  = fo.sclr;
  assign FIFO_rdreq = fo.rd && !FIFO_empty;
  assign Tx_valid   = fo.hdr || fo.snd;
  assign Tx_data    = fo.hdr ? HDR_BYTE : tx_hold;
  assign Busy       = fo.busy;
  assign Frame_done = fo.done;

  a_rd_empty: assert property (
    @(posedge Clk) disable iff (!Reset_n)
    !(FIFO_rdreq && FIFO_empty));

  a_sclr_one: assert property (
    @(posedge Clk) disable iff (!Reset_n)
    FIFO_sclr |=> !FIFO_sclr);

  a_tx_hold: assert property (
    @(posedge Clk) disable iff (!Reset_n)
    (Tx_valid && !Tx_ready) |=>
      (Tx_valid && $stable(Tx_data)));

endmodule
